// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the pipeline MEM stage
// (priority) and a DMA/loader requester using a req/ack handshake. A
// starvation counter forces a DMA slot after STARVE_LIMIT CPU-won cycles
// while a DMA request is pending.
// Optional feature macro: DMEM_ARB_STATS_EN adds saturating stall/transfer
// statistics counters (stat_cpu_stalls, stat_dma_xfers).
module dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [1:0]  cpu_type,
   input  logic [63:0] cpu_addr,
   input  logic [63:0] cpu_wdata,
   output logic [63:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [1:0]  dma_type,
   input  logic [63:0] dma_addr,
   input  logic [63:0] dma_wdata,
   output logic        dma_ack,
   output logic [63:0] dma_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [1:0]  mem_type,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0] stat_cpu_stalls,
   output logic [31:0] stat_dma_xfers
`endif
);

   typedef enum logic [0:0] {IDLE, ACK} state_t;

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   state_t      state, stateNext;
   logic [7:0]  starveCnt, starveCntNext;
   logic [63:0] dmaRdataReg, dmaRdataNext;
   logic        dmaGrant;
   logic        cpuActive;

   // Arbitration decision and memory-port steering for the current cycle.
   // The grant is suppressed while reset is held so a cut-off grant cycle
   // never reaches the memory.
   always_comb begin
      cpuActive = cpu_read | cpu_write;
      dmaGrant  = !reset && (state == IDLE) && dma_req &&
                  (!cpuActive || (starveCnt == LIMIT));

      mem_read  = cpu_read & !reset;
      mem_write = cpu_write & !reset;
      mem_type  = cpu_type;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      cpu_stall = 1'b0;

      if (dmaGrant) begin
         mem_read  = !dma_we;
         mem_write = dma_we;
         mem_type  = dma_type;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         cpu_stall = cpuActive;
      end
   end

   // Next-state logic: grant moves to ACK and captures read data; otherwise
   // the starvation counter tracks CPU-won cycles with a DMA request pending.
   always_comb begin
      stateNext     = state;
      starveCntNext = starveCnt;
      dmaRdataNext  = dmaRdataReg;

      case (state)
         IDLE: begin
            if (dmaGrant) begin
               stateNext     = ACK;
               starveCntNext = 8'd0;
               dmaRdataNext  = dma_we ? 64'd0 : mem_rdata;
            end else if (!dma_req) begin
               starveCntNext = 8'd0;
            end else if (cpuActive && (starveCnt != LIMIT)) begin
               starveCntNext = starveCnt + 8'd1;
            end
         end
         ACK: begin
            stateNext     = IDLE;
            starveCntNext = 8'd0;
         end
         default: begin
            stateNext     = IDLE;
            starveCntNext = 8'd0;
         end
      endcase
   end

   // State register with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         starveCnt   <= 8'd0;
         dmaRdataReg <= 64'd0;
      end else begin
         state       <= stateNext;
         starveCnt   <= starveCntNext;
         dmaRdataReg <= dmaRdataNext;
      end
   end

   // The ack pulse is exactly the single ACK cycle.
   always_comb begin
      dma_ack   = (state == ACK);
      dma_rdata = dmaRdataReg;
      cpu_rdata = mem_rdata;
   end

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] statStallsReg;
   logic [31:0] statXfersReg;

   // Saturating counters of stalled CPU cycles and completed DMA transfers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         statStallsReg <= 32'd0;
         statXfersReg  <= 32'd0;
      end else begin
         if (cpu_stall && (statStallsReg != 32'hFFFF_FFFF))
            statStallsReg <= statStallsReg + 32'd1;
         if (dma_ack && (statXfersReg != 32'hFFFF_FFFF))
            statXfersReg <= statXfersReg + 32'd1;
      end
   end

   // Expose the counters.
   always_comb begin
      stat_cpu_stalls = statStallsReg;
      stat_dma_xfers  = statXfersReg;
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter. A STARVE_LIMIT=4 instance drives a
// small memory model; a STARVE_LIMIT=0 instance shares the inputs and is
// checked for its arbitration pattern only.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_read = 1'b0, cpu_write = 1'b0;
   logic [1:0]  cpu_type = 2'b00;
   logic [63:0] cpu_addr = 64'd0, cpu_wdata = 64'd0;
   logic        dma_req = 1'b0, dma_we = 1'b0;
   logic [1:0]  dma_type = 2'b00;
   logic [63:0] dma_addr = 64'd0, dma_wdata = 64'd0;

   logic [63:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_stall, dma_ack, mem_read, mem_write;
   logic [1:0]  mem_type;

   logic [63:0] cpuRdata0, dmaRdata0, memAddr0, memWdata0;
   logic        cpuStall0, dmaAck0, memRead0, memWrite0;
   logic [1:0]  memType0;
   logic [63:0] memRdata0 = 64'h0123_4567_89AB_CDEF;

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] stat_cpu_stalls, stat_dma_xfers, statStalls0, statXfers0;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [63:0] mem [0:31];
   logic        memClear = 1'b1;

   always #5 clk = ~clk;

   // Memory model: combinational read, write on posedge.
   always @(posedge clk) begin
      if (memClear) begin
         for (int i = 0; i < 32; i++) mem[i] <= 64'd0;
      end else if (mem_write) begin
         mem[mem_addr[7:3]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr[7:3]];

   dmem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_type(cpu_type),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_type(dma_type),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
      .dma_rdata(dma_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_type(mem_type),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      , .stat_cpu_stalls(stat_cpu_stalls), .stat_dma_xfers(stat_dma_xfers)
`endif
   );

   dmem_arbiter #(.STARVE_LIMIT(0)) dut0 (
      .clk(clk), .reset(reset),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_type(cpu_type),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpuRdata0),
      .cpu_stall(cpuStall0),
      .dma_req(dma_req), .dma_we(dma_we), .dma_type(dma_type),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dmaAck0),
      .dma_rdata(dmaRdata0),
      .mem_read(memRead0), .mem_write(memWrite0), .mem_type(memType0),
      .mem_addr(memAddr0), .mem_wdata(memWdata0), .mem_rdata(memRdata0)
`ifdef DMEM_ARB_STATS_EN
      , .stat_cpu_stalls(statStalls0), .stat_dma_xfers(statXfers0)
`endif
   );

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cpu_read = 1'b1; cpu_addr = 64'h40;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 64'h40;
      nextCycle();
      nextCycle();
      vectors++;
      if (dma_ack !== 1'b0 || dma_rdata !== 64'd0) begin
         $display("FAIL reset_regs: dma_ack=%b dma_rdata=%h, required 0/0", dma_ack, dma_rdata);
         miscompares++;
      end
      vectors++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || cpu_stall !== 1'b0) begin
         $display("FAIL reset_outs: mem_read=%b mem_write=%b cpu_stall=%b, required 0/0/0",
                  mem_read, mem_write, cpu_stall);
         miscompares++;
      end
      $display("reset: dma_ack=%b dma_rdata=%h mem_rd=%b mem_wr=%b stall=%b",
               dma_ack, dma_rdata, mem_read, mem_write, cpu_stall);
      cpu_read = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
      memClear = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_dma_write();
      nextCycle();
      dma_req = 1'b1; dma_we = 1'b1; dma_type = 2'b11;
      dma_addr = 64'h40; dma_wdata = 64'hDEAD_BEEF;
      @(negedge clk);
      vectors++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 64'h40 ||
          mem_type !== 2'b11 || mem_wdata !== 64'hDEAD_BEEF || cpu_stall !== 1'b0) begin
         $display("FAIL dma_wr_grant: wr=%b rd=%b addr=%h type=%b wdata=%h stall=%b, required 1/0/40/11/deadbeef/0",
                  mem_write, mem_read, mem_addr, mem_type, mem_wdata, cpu_stall);
         miscompares++;
      end
      vectors++;
      if (dma_ack !== 1'b0) begin
         $display("FAIL dma_wr_early_ack: dma_ack=%b, required 0", dma_ack);
         miscompares++;
      end
      nextCycle();
      dma_req = 1'b0;
      cpu_read = 1'b1; cpu_addr = 64'h40;
      @(negedge clk);
      vectors++;
      if (dma_ack !== 1'b1) begin
         $display("FAIL dma_wr_ack: dma_ack=%b, required 1", dma_ack);
         miscompares++;
      end
      vectors++;
      if (cpu_rdata !== 64'hDEAD_BEEF || cpu_stall !== 1'b0 || mem_read !== 1'b1) begin
         $display("FAIL cpu_load_after_dma: rdata=%h stall=%b mem_read=%b, required deadbeef/0/1",
                  cpu_rdata, cpu_stall, mem_read);
         miscompares++;
      end
      $display("dma write 0x40: ack=%b cpu load rdata=%h stall=%b", dma_ack, cpu_rdata, cpu_stall);
      nextCycle();
      cpu_read = 1'b0;
      @(negedge clk);
      vectors++;
      if (dma_ack !== 1'b0) begin
         $display("FAIL dma_wr_ack_pulse: dma_ack=%b, required 0", dma_ack);
         miscompares++;
      end
   endtask

   task automatic test_dma_read();
      nextCycle();
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 64'h40; dma_type = 2'b11;
      @(negedge clk);
      vectors++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 64'h40 || dma_ack !== 1'b0) begin
         $display("FAIL dma_rd_grant: rd=%b wr=%b addr=%h ack=%b, required 1/0/40/0",
                  mem_read, mem_write, mem_addr, dma_ack);
         miscompares++;
      end
      nextCycle();
      dma_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (dma_ack !== 1'b1 || dma_rdata !== 64'hDEAD_BEEF) begin
         $display("FAIL dma_rd_ack: ack=%b rdata=%h, required 1/deadbeef", dma_ack, dma_rdata);
         miscompares++;
      end
      $display("dma read 0x40: ack=%b rdata=%h", dma_ack, dma_rdata);
   endtask

   task automatic test_reset_mid_ack();
      nextCycle();
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 64'h40;
      nextCycle();
      vectors++;
      if (dma_ack !== 1'b1) begin
         $display("FAIL mid_ack_setup: dma_ack=%b, required 1", dma_ack);
         miscompares++;
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (dma_ack !== 1'b0 || dma_rdata !== 64'd0) begin
         $display("FAIL mid_ack_reset: ack=%b rdata=%h, required 0/0", dma_ack, dma_rdata);
         miscompares++;
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++;
      if (mem_read !== 1'b1 || dma_ack !== 1'b0) begin
         $display("FAIL mid_ack_regrant: mem_read=%b ack=%b, required 1/0", mem_read, dma_ack);
         miscompares++;
      end
      nextCycle();
      dma_req = 1'b0;
      vectors++;
      if (dma_ack !== 1'b1 || dma_rdata !== 64'hDEAD_BEEF) begin
         $display("FAIL mid_ack_reack: ack=%b rdata=%h, required 1/deadbeef", dma_ack, dma_rdata);
         miscompares++;
      end
      $display("reset mid-ACK: regrant ack=%b rdata=%h", dma_ack, dma_rdata);
      nextCycle();
   endtask

   task automatic test_starvation();
      logic expStall, expAck, expStall0, expAck0;
      cpu_read = 1'b1; cpu_addr = 64'h40;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 64'h40;
      for (int c = 1; c <= 12; c++) begin
         expStall  = (c == 5) || (c == 11);
         expAck    = (c == 6) || (c == 12);
         expStall0 = (c % 2) == 1;
         expAck0   = (c % 2) == 0;
         @(negedge clk);
         vectors++;
         if (cpu_stall !== expStall || dma_ack !== expAck) begin
            $display("FAIL starve_l4 cycle %0d: stall=%b ack=%b, required %b/%b",
                     c, cpu_stall, dma_ack, expStall, expAck);
            miscompares++;
         end
         vectors++;
         if (cpuStall0 !== expStall0 || dmaAck0 !== expAck0) begin
            $display("FAIL starve_l0 cycle %0d: stall=%b ack=%b, required %b/%b",
                     c, cpuStall0, dmaAck0, expStall0, expAck0);
            miscompares++;
         end
         if (expAck) begin
            vectors++;
            if (dma_rdata !== 64'hDEAD_BEEF) begin
               $display("FAIL starve_rdata cycle %0d: rdata=%h, required deadbeef", c, dma_rdata);
               miscompares++;
            end
         end
         $display("starve cycle %0d: L4 stall=%b ack=%b  L0 stall=%b ack=%b",
                  c, cpu_stall, dma_ack, cpuStall0, dmaAck0);
         nextCycle();
      end
      dma_req = 1'b0;
      cpu_read = 1'b0;
      nextCycle();
   endtask

   task automatic test_withdrawal();
      logic expStall, expAck;
      cpu_read = 1'b1; cpu_addr = 64'h80;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 64'h80; dma_wdata = 64'h1111;
      for (int c = 1; c <= 5; c++) begin
         if (c == 3) dma_req = 1'b0;
         @(negedge clk);
         vectors++;
         if (dma_ack !== 1'b0 || cpu_stall !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 64'h80) begin
            $display("FAIL withdraw cycle %0d: ack=%b stall=%b wr=%b addr=%h, required 0/0/0/80",
                     c, dma_ack, cpu_stall, mem_write, mem_addr);
            miscompares++;
         end
         $display("withdraw cycle %0d: req=%b ack=%b stall=%b", c, dma_req, dma_ack, cpu_stall);
         nextCycle();
      end
      @(negedge clk);
      vectors++;
      if (cpu_rdata !== 64'd0) begin
         $display("FAIL withdraw_no_write: mem[0x80]=%h, required 0", cpu_rdata);
         miscompares++;
      end
      // A fresh request must again wait the full starvation window.
      nextCycle();
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 64'h40;
      for (int c = 1; c <= 6; c++) begin
         expStall = (c == 5);
         expAck   = (c == 6);
         @(negedge clk);
         vectors++;
         if (cpu_stall !== expStall || dma_ack !== expAck) begin
            $display("FAIL rerequest cycle %0d: stall=%b ack=%b, required %b/%b",
                     c, cpu_stall, dma_ack, expStall, expAck);
            miscompares++;
         end
         $display("rerequest cycle %0d: stall=%b ack=%b", c, cpu_stall, dma_ack);
         nextCycle();
         if (c == 5) dma_req = 1'b0;
      end
      cpu_read = 1'b0;
      nextCycle();
`ifdef DMEM_ARB_STATS_EN
      vectors++;
      if (stat_cpu_stalls !== 32'd3 || stat_dma_xfers !== 32'd4) begin
         $display("FAIL stats: stalls=%0d xfers=%0d, required 3/4", stat_cpu_stalls, stat_dma_xfers);
         miscompares++;
      end
      $display("stats: stalls=%0d xfers=%0d", stat_cpu_stalls, stat_dma_xfers);
`endif
   endtask

   initial begin
      test_reset();
      test_dma_write();
      test_dma_read();
      test_reset_mid_ack();
      test_starvation();
      test_withdrawal();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
